// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feeder.
// Holds the sequencer state encoding and drain-length arithmetic.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_FILL,
    W_BURST,
    STREAM,
    DRAIN
  } feeder_state_t;

  // Worst-case travel of the last injected value through skew and array.
  function automatic int drain_len(
    input int rows,
    input int cols,
    input int skew,
    input int pe_lat
  );
    return (rows - 1) * skew + (cols - 1) * skew + rows * pe_lat;
  endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// Enable-gated shift line used to skew one activation row.
// A depth of zero degenerates to a wire.
module systolic_skew_line #(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_en,
  input  logic [DATA_SIZE-1:0] i_d,
  output logic [DATA_SIZE-1:0] o_q
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = ^{clk, reset, i_en};
    assign o_q = i_d;
  end else begin : g_line
    logic [DATA_SIZE-1:0] r_sr [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < DEPTH; i++)
          r_sr[i] <= '0;
      end else if (i_en) begin
        r_sr[0] <= i_d;
        for (int i = 1; i < DEPTH; i++)
          r_sr[i] <= r_sr[i-1];
      end
    end

    assign o_q = r_sr[DEPTH-1];
  end

endmodule

// File: rtl/systolic_feeder.sv
// Sequencer feeding weights and skewed activations into the PE array.
// Array-facing outputs are registered from the next state.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int SKEW      = 3,
  parameter int PE_LAT    = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_vec,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [COLS*DATA_SIZE-1:0] w_data,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [ROWS*DATA_SIZE-1:0] a_data,
  output logic                      pe_enable,
  output logic                      pe_ld_wt,
  output logic [COLS*DATA_SIZE-1:0] col_sum,
  output logic [ROWS*DATA_SIZE-1:0] row_data,
  output logic                      busy,
  output logic                      done
);

  localparam int DLEN = drain_len(ROWS, COLS, SKEW, PE_LAT);
  localparam int DW   = $clog2(DLEN + 1);
  localparam int KW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ROWS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DLEN - 1);

  feeder_state_t r_state;
  feeder_state_t w_next;

  logic [KW-1:0]             r_k;
  logic [KW-1:0]             w_k_next;
  logic [CNT_W-1:0]          r_rem;
  logic [DW-1:0]             r_dcnt;
  logic [COLS*DATA_SIZE-1:0] r_buf [ROWS];

  logic                      r_pe_enable;
  logic                      r_pe_ld_wt;
  logic [COLS*DATA_SIZE-1:0] r_col_sum;
  logic [ROWS*DATA_SIZE-1:0] r_row_data;
  logic [ROWS*DATA_SIZE-1:0] w_inj;
  logic [ROWS*DATA_SIZE-1:0] w_skewed;

  logic w_w_ready;
  logic w_a_ready;
  logic w_busy;
  logic w_done;
  logic w_w_xfer;
  logic w_a_xfer;
  logic w_shift;
  logic w_en_next;

  assign w_w_xfer = w_valid & w_w_ready;
  assign w_a_xfer = a_valid & w_a_ready;
  assign w_shift  = (r_state == STREAM) || (r_state == DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (start) w_next = W_FILL;
      W_FILL:
        if (w_w_xfer && r_k == K_LAST) w_next = W_BURST;
      W_BURST:
        if (r_k == K_LAST)
          w_next = (r_rem == '0) ? DRAIN : STREAM;
      STREAM:
        if (r_rem == '0 ||
            (w_a_xfer && r_rem == CNT_W'(1)))
          w_next = DRAIN;
      DRAIN:
        if (r_dcnt == '0) w_next = IDLE;
      default:
        w_next = IDLE;
    endcase
  end

  always_comb begin
    w_w_ready = 1'b0;
    w_a_ready = 1'b0;
    w_busy    = 1'b1;
    w_done    = 1'b0;
    unique case (r_state)
      IDLE:    w_busy    = 1'b0;
      W_FILL:  w_w_ready = 1'b1;
      W_BURST: ;
      STREAM:  w_a_ready = (r_rem != '0);
      DRAIN:   w_done    = (r_dcnt == '0);
      default: w_busy    = 1'b0;
    endcase
  end

  // Beat index doubles as fill pointer and burst pointer.
  always_comb begin
    w_k_next = '0;
    if (r_state == W_FILL && w_next == W_FILL)
      w_k_next = r_k + KW'(w_w_xfer);
    else if (r_state == W_BURST && w_next == W_BURST)
      w_k_next = r_k + KW'(1);
  end

  assign w_en_next = (w_next == W_BURST) ||
                     (w_next == STREAM)  ||
                     (w_next == DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k    <= '0;
      r_rem  <= '0;
      r_dcnt <= '0;
      for (int i = 0; i < ROWS; i++)
        r_buf[i] <= '0;
    end else begin
      r_k <= w_k_next;
      if (w_w_xfer)
        r_buf[r_k] <= w_data;
      if (r_state == IDLE && start)
        r_rem <= num_vec;
      else if (w_a_xfer && r_rem != '0)
        r_rem <= r_rem - CNT_W'(1);
      if (w_next == DRAIN && r_state != DRAIN)
        r_dcnt <= D_LAST;
      else if (r_state == DRAIN && r_dcnt != '0)
        r_dcnt <= r_dcnt - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pe_enable <= 1'b0;
      r_pe_ld_wt  <= 1'b0;
      r_col_sum   <= '0;
      r_row_data  <= '0;
    end else begin
      r_pe_enable <= w_en_next;
      r_pe_ld_wt  <= (w_next == W_BURST);
      r_col_sum   <= (w_next == W_BURST) ?
                     r_buf[w_k_next] : '0;
      if (w_shift)
        r_row_data <= w_skewed;
    end
  end

  // Bubbles inject zeros so the wavefront keeps moving.
  assign w_inj = w_a_xfer ? a_data : '0;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    systolic_skew_line #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (r * SKEW)
    ) u_line (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_shift),
      .i_d   (w_inj[r*DATA_SIZE +: DATA_SIZE]),
      .o_q   (w_skewed[r*DATA_SIZE +: DATA_SIZE])
    );
  end

  assign w_ready   = w_w_ready;
  assign a_ready   = w_a_ready;
  assign busy      = w_busy;
  assign done      = w_done;
  assign pe_enable = r_pe_enable;
  assign pe_ld_wt  = r_pe_ld_wt;
  assign col_sum   = r_col_sum;
  assign row_data  = r_row_data;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder on a 2x2 array.
// Driver queues expected outputs; a negedge monitor checks them.
module tb_systolic_feeder;

  localparam int DS   = 32;
  localparam int R    = 2;
  localparam int C    = 2;
  localparam int S    = 3;
  localparam int L    = 4;
  localparam int CW   = 16;
  localparam int DLEN = (R-1)*S + (C-1)*S + R*L;

  logic          clk = 0;
  logic          reset = 1;
  logic          start = 0;
  logic [CW-1:0] num_vec = '0;
  logic          w_valid = 0;
  logic          w_ready;
  logic [C*DS-1:0] w_data = '0;
  logic          a_valid = 0;
  logic          a_ready;
  logic [R*DS-1:0] a_data = '0;
  logic          pe_enable;
  logic          pe_ld_wt;
  logic [C*DS-1:0] col_sum;
  logic [R*DS-1:0] row_data;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  systolic_feeder #(
    .DATA_SIZE (DS),
    .ROWS      (R),
    .COLS      (C),
    .SKEW      (S),
    .PE_LAT    (L),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_vec   (num_vec),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .pe_enable (pe_enable),
    .pe_ld_wt  (pe_ld_wt),
    .col_sum   (col_sum),
    .row_data  (row_data),
    .busy      (busy),
    .done      (done)
  );

  int tests = 0;
  int fails = 0;

  logic [C*DS-1:0] wq [$];
  logic [DS-1:0]   rq [R][$];

  bit mon_en = 0;
  bit job_active = 0;
  bit prev_done = 0;
  bit prev_ld = 0;
  int en_idx = 0;
  int ld_run = 0;
  int mon_x = 0;
  int exp_n = 0;
  int exp_last = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: got nothing want entry", nm);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_done) begin
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("en_after_done", 64'(pe_enable), 64'd0);
      end
      prev_done = done;
      if (!job_active)
        chk("w_ready_idle", 64'(w_ready), 64'd0);
      if (a_ready)
        chk("a_ready_budget", 64'(mon_x < exp_n), 64'd1);
      if (a_valid && a_ready)
        mon_x++;
      if (!pe_enable) begin
        chk("col_sum_idle", col_sum, 64'd0);
        chk("row_data_idle", row_data, 64'd0);
        chk("ld_idle", 64'(pe_ld_wt), 64'd0);
      end else if (pe_ld_wt) begin
        ld_run++;
        if (wq.size() == 0) miss("col_sum_burst");
        else chk("col_sum_burst", col_sum, wq.pop_front());
      end else begin
        if (prev_ld) begin
          chk("burst_len", 64'(ld_run), 64'(R));
          ld_run = 0;
        end
        chk("col_sum_stream", col_sum, 64'd0);
        for (int r = 0; r < R; r++) begin
          if (rq[r].size() == 0)
            miss($sformatf("row_data%0d", r));
          else
            chk($sformatf("row_data%0d", r),
                64'(row_data[r*DS +: DS]),
                64'(rq[r].pop_front()));
        end
      end
      if (done) begin
        chk("done_in_job", 64'(job_active), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_index", 64'(en_idx), 64'(exp_last));
        chk("xfer_count", 64'(mon_x), 64'(exp_n));
        job_active = 0;
      end
      if (pe_enable && !pe_ld_wt)
        en_idx++;
      prev_ld = pe_enable && pe_ld_wt;
    end
  end

  task automatic run_job(input int n,
                         input bit directed,
                         input bit poke);
    int wi = 0;
    int cyc = 0;
    int didx = 0;
    bit gapped = 0;
    wq.delete();
    for (int r = 0; r < R; r++) begin
      rq[r].delete();
      // Row r shows an injected value 1+r*S enabled cycles later.
      for (int k = 0; k < 1 + r*S; k++)
        rq[r].push_back(DS'(0));
    end
    en_idx = 0;
    ld_run = 0;
    mon_x = 0;
    prev_ld = 0;
    exp_n = n;
    exp_last = (n == 0) ? DLEN - 1 : -1;
    job_active = 1;
    start = 1;
    num_vec = CW'(n);
    @(posedge clk); #1;
    start = 0;
    num_vec = CW'($urandom_range(0, 9));
    while (job_active && cyc < 2000) begin
      w_valid = 0;
      if (wi < R) begin
        if (directed) begin
          w_valid = !(wi == 1 && !gapped);
          if (wi == 1) gapped = 1;
        end else begin
          w_valid = ($urandom_range(0, 3) != 0);
        end
      end
      if (directed)
        w_data = (wi == 0) ? {32'd6, 32'd5} : {32'd8, 32'd7};
      else
        w_data = {$urandom(), $urandom()};
      if (directed) begin
        a_valid = (didx >= 2);
        a_data = {32'd2, 32'd1};
      end else begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_data = {$urandom(), $urandom()};
      end
      start = poke &&
              ((didx % 4) == 3 || $urandom_range(0, 4) == 0);
      if (start) num_vec = CW'($urandom_range(1, 9));
      @(negedge clk);
      if (w_valid && w_ready) begin
        wq.push_back(w_data);
        wi++;
      end
      if (pe_enable && !pe_ld_wt) begin
        for (int r = 0; r < R; r++)
          rq[r].push_back((a_valid && a_ready) ?
                          a_data[r*DS +: DS] : DS'(0));
        if (a_valid && a_ready)
          exp_last = didx + DLEN;
        didx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    w_valid = 0;
    a_valid = 0;
    if (job_active) begin
      tests++;
      fails++;
      $display("FAIL job_timeout: got no done want done");
      job_active = 0;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      start = 0;
      w_valid = $urandom_range(0, 1);
      a_valid = $urandom_range(0, 1);
      w_data = {$urandom(), $urandom()};
      a_data = {$urandom(), $urandom()};
      @(posedge clk); #1;
    end
    w_valid = 0;
    a_valid = 0;
  endtask

  initial begin
    int c;
    #2 reset = 0;
    @(negedge clk);
    chk("rst_pe_enable", 64'(pe_enable), 64'd0);
    chk("rst_ld", 64'(pe_ld_wt), 64'd0);
    chk("rst_col_sum", col_sum, 64'd0);
    chk("rst_row_data", row_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'({w_ready, a_ready}), 64'd0);
    @(posedge clk); #1;
    reset = 1;
    mon_en = 1;
    @(posedge clk); #1;

    run_job(1, 1'b1, 1'b0);
    idle(3);
    run_job(0, 1'b0, 1'b0);
    idle(3);
    run_job(2, 1'b0, 1'b1);
    idle(4);
    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(0, 6), 1'b0,
              1'($urandom_range(0, 1)));
      idle($urandom_range(1, 4));
    end

    mon_en = 0;
    start = 1;
    num_vec = CW'(5);
    @(posedge clk); #1;
    start = 0;
    w_valid = 1;
    a_valid = 1;
    c = 0;
    while (!a_ready && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    if (c == 50) begin
      tests++;
      fails++;
      $display("FAIL rst_reach_stream: got no a_ready want a_ready");
    end
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 0;
    @(negedge clk);
    chk("rst2_pe_enable", 64'(pe_enable), 64'd0);
    chk("rst2_row_data", row_data, 64'd0);
    chk("rst2_busy", 64'(busy), 64'd0);
    chk("rst2_a_ready", 64'(a_ready), 64'd0);
    chk("rst2_col_sum", col_sum, 64'd0);
    chk("rst2_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    chk("rst2_hold_busy", 64'(busy), 64'd0);
    w_valid = 0;
    a_valid = 0;
    reset = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
